// File: rtl/vector_add_engine_if.sv
// AXI3-style gmem bus between the vector-add engine (master) and memory (slave).
interface vector_add_engine_if #(
    parameter int ADDR_W = 33,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 4
);
    // Read address channel
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic [LEN_W-1:0]  arlen;
    logic [1:0]        arlock;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [3:0]        arregion;
    logic [2:0]        arsize;
    // Read data channel
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic [1:0]        rresp;
    // Write address channel
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [1:0]        awburst;
    logic [3:0]        awcache;
    logic [LEN_W-1:0]  awlen;
    logic [1:0]        awlock;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic [3:0]        awregion;
    logic [2:0]        awsize;
    // Write data channel
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic                wlast;
    logic [DATA_W/8-1:0] wstrb;
    // Write response channel
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    modport master (
        output arvalid, araddr, arburst, arcache, arlen, arlock, arprot, arqos, arregion, arsize,
        input  arready,
        input  rvalid, rdata, rlast, rresp,
        output rready,
        output awvalid, awaddr, awburst, awcache, awlen, awlock, awprot, awqos, awregion, awsize,
        input  awready,
        output wvalid, wdata, wlast, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arburst, arcache, arlen, arlock, arprot, arqos, arregion, arsize,
        output arready,
        output rvalid, rdata, rlast, rresp,
        input  rready,
        input  awvalid, awaddr, awburst, awcache, awlen, awlock, awprot, awqos, awregion, awsize,
        output awready,
        input  wvalid, wdata, wlast, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/vector_add_engine.sv
// Single-shot vector-add engine: fetch ARG, then A and B, write RES = A + B + ARG
// per 32-bit lane, and report the lane sum on io_ap_return.
module vector_add_engine #(
    parameter int ADDR_W = 33,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_start,
    output logic                io_done,
    input  logic [63:0]         io_pargs,
    input  logic [63:0]         io_pdata,
    input  logic [63:0]         io_pres,
    input  logic [31:0]         io_args_len,
    input  logic [31:0]         io_data_len,
    output logic [31:0]         io_ap_return,
    vector_add_engine_if.master m_axi_gmem
);
    localparam int LANES = DATA_W / 32;

    typedef enum logic [2:0] {
        S_IDLE, S_AR_ARG, S_R_ARG, S_AR_DAT, S_R_A, S_R_B, S_WR, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic              rready_q, rready_d;
    logic              arg_got_q, arg_got_d;
    logic [DATA_W-1:0] arg_q, arg_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [31:0]       sum_q, sum_d;
    logic              awvalid_q, awvalid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              aw_done_q, aw_done_d;
    logic              wvalid_q, wvalid_d;
    logic              w_done_q, w_done_d;
    logic              done_q, done_d;
    logic [31:0]       ap_return_q, ap_return_d;

    logic ar_hs, r_hs, aw_hs, w_hs;
    assign ar_hs = arvalid_q & m_axi_gmem.arready;
    assign r_hs  = rready_q  & m_axi_gmem.rvalid;
    assign aw_hs = awvalid_q & m_axi_gmem.awready;
    assign w_hs  = wvalid_q  & m_axi_gmem.wready;

    // Next-state and next-output logic for the whole transaction sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arg_got_d   = arg_got_q;
        arg_d       = arg_q;
        a_d         = a_q;
        res_d       = res_q;
        sum_d       = sum_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        aw_done_d   = aw_done_q;
        wvalid_d    = wvalid_q;
        w_done_d    = w_done_q;
        done_d      = 1'b0;
        ap_return_d = ap_return_q;

        case (state_q)
            S_IDLE: begin
                if (io_start) state_d = S_AR_ARG;
            end
            S_AR_ARG: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R_ARG;
                end else if (!arvalid_q) begin
                    arvalid_d = 1'b1;
                    araddr_d  = io_pargs[ADDR_W-1:0];
                    arlen_d   = '0;
                end
            end
            S_R_ARG: begin
                // Keep only the first beat; anything after it is drained up to RLAST.
                if (r_hs) begin
                    if (!arg_got_q) begin
                        arg_d     = m_axi_gmem.rdata;
                        arg_got_d = 1'b1;
                    end
                    if (m_axi_gmem.rlast) begin
                        arg_got_d = 1'b0;
                        state_d   = S_AR_DAT;
                    end
                end
            end
            S_AR_DAT: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R_A;
                end else if (!arvalid_q) begin
                    arvalid_d = 1'b1;
                    araddr_d  = io_pdata[ADDR_W-1:0];
                    arlen_d   = LEN_W'(1);
                end
            end
            S_R_A: begin
                if (r_hs) begin
                    a_d     = m_axi_gmem.rdata;
                    state_d = S_R_B;
                end
            end
            S_R_B: begin
                // B is consumed straight off the bus; lanes wrap independently.
                if (r_hs) begin
                    sum_d = '0;
                    for (int i = 0; i < LANES; i++) begin
                        res_d[32*i +: 32] = a_q[32*i +: 32] + m_axi_gmem.rdata[32*i +: 32]
                                          + arg_q[32*i +: 32];
                        sum_d = sum_d + res_d[32*i +: 32];
                    end
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // AW and W retire independently; the posted write does not wait for B.
                if (!aw_done_q) begin
                    if (aw_hs) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end else if (!awvalid_q) begin
                        awvalid_d = 1'b1;
                        awaddr_d  = io_pres[ADDR_W-1:0];
                    end
                end
                if (!w_done_q) begin
                    if (w_hs) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        wvalid_d = 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    done_d      = 1'b1;
                    ap_return_d = sum_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rready_d = (state_d == S_R_ARG) || (state_d == S_R_A) || (state_d == S_R_B);
    end

    // State and registered outputs; reset aborts any run in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            rready_q    <= 1'b0;
            arg_got_q   <= 1'b0;
            arg_q       <= '0;
            a_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            aw_done_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            w_done_q    <= 1'b0;
            done_q      <= 1'b0;
            ap_return_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            rready_q    <= rready_d;
            arg_got_q   <= arg_got_d;
            arg_q       <= arg_d;
            a_q         <= a_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            aw_done_q   <= aw_done_d;
            wvalid_q    <= wvalid_d;
            w_done_q    <= w_done_d;
            done_q      <= done_d;
            ap_return_q <= ap_return_d;
        end
    end

    assign m_axi_gmem.arvalid  = arvalid_q;
    assign m_axi_gmem.araddr   = araddr_q;
    assign m_axi_gmem.arlen    = arlen_q;
    assign m_axi_gmem.arburst  = 2'b01;
    assign m_axi_gmem.arsize   = 3'b101;
    assign m_axi_gmem.arcache  = 4'b0011;
    assign m_axi_gmem.arlock   = '0;
    assign m_axi_gmem.arprot   = '0;
    assign m_axi_gmem.arqos    = '0;
    assign m_axi_gmem.arregion = '0;
    assign m_axi_gmem.rready   = rready_q;

    assign m_axi_gmem.awvalid  = awvalid_q;
    assign m_axi_gmem.awaddr   = awaddr_q;
    assign m_axi_gmem.awlen    = '0;
    assign m_axi_gmem.awburst  = 2'b01;
    assign m_axi_gmem.awsize   = 3'b101;
    assign m_axi_gmem.awcache  = 4'b0011;
    assign m_axi_gmem.awlock   = '0;
    assign m_axi_gmem.awprot   = '0;
    assign m_axi_gmem.awqos    = '0;
    assign m_axi_gmem.awregion = '0;

    assign m_axi_gmem.wvalid   = wvalid_q;
    assign m_axi_gmem.wdata    = res_q;
    assign m_axi_gmem.wlast    = 1'b1;
    assign m_axi_gmem.wstrb    = '1;
    assign m_axi_gmem.bready   = 1'b1;

    assign io_done      = done_q;
    assign io_ap_return = ap_return_q;

    // Reserved lengths, upper pointer bits and response codes carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{io_args_len, io_data_len, io_pargs[63:ADDR_W], io_pdata[63:ADDR_W],
                             io_pres[63:ADDR_W], m_axi_gmem.rresp, m_axi_gmem.bvalid,
                             m_axi_gmem.bresp};
endmodule

// File: tb/tb_vector_add_engine.sv
// Bench for vector_add_engine: behavioural gmem slave plus lane-arithmetic reference model.
`timescale 1ns/1ps
module tb_vector_add_engine;
    localparam int ADDR_W = 33;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_start = 1'b0;
    logic        io_done;
    logic [63:0] io_pargs = '0, io_pdata = '0, io_pres = '0;
    logic [31:0] io_args_len = '0, io_data_len = '0;
    logic [31:0] io_ap_return;

    always #5 clock = ~clock;

    vector_add_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) gmem ();

    vector_add_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_start     (io_start),
        .io_done      (io_done),
        .io_pargs     (io_pargs),
        .io_pdata     (io_pdata),
        .io_pres      (io_pres),
        .io_args_len  (io_args_len),
        .io_data_len  (io_data_len),
        .io_ap_return (io_ap_return),
        .m_axi_gmem   (gmem)
    );

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len; } a_rec_t;
    typedef struct packed { logic [DATA_W-1:0] data; logic last; logic [DATA_W/8-1:0] strb; } w_rec_t;
    typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;

    int n_checks = 0;
    int n_err    = 0;

    // Slave knobs and observation logs
    int ar_delay = 0, aw_delay = 0, w_delay = 0, extra_arg_beats = 0;
    a_rec_t ar_log[$];
    a_rec_t aw_log[$];
    w_rec_t w_log[$];
    beat_t  rq[$];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    int done_cnt = 0, ar_drop = 0, rr_overlap = 0, aw_valid_cycles = 0, w_valid_cycles = 0;
    int cyc = 0, w_hs_cyc = 0, done_cyc = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, nb = 0;
    bit keep, ar_hs, r_hs_pend, ar_wait_prev;
    logic [ADDR_W-1:0] ar_addr_prev;
    logic [LEN_W-1:0]  ar_len_prev;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return '0;
    endfunction

    function automatic logic [DATA_W-1:0] rand_vec();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Reference: each 32-bit lane is ARG + A + B modulo 2^32.
    function automatic logic [DATA_W-1:0] model_res(input logic [DATA_W-1:0] arg, a, b);
        logic [DATA_W-1:0] r;
        logic [31:0] x, y, z;
        for (int i = 0; i < DATA_W / 32; i++) begin
            x = arg[32*i +: 32];
            y = a[32*i +: 32];
            z = b[32*i +: 32];
            r[32*i +: 32] = x + y + z;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_sum(input logic [DATA_W-1:0] r);
        logic [31:0] s = '0;
        for (int i = 0; i < DATA_W / 32; i++) s = s + r[32*i +: 32];
        return s;
    endfunction

    // Memory slave and bus monitor: all decisions are made on the falling edge for the next rising edge.
    initial begin
        gmem.arready = 1'b0; gmem.rvalid = 1'b0; gmem.rdata = '0; gmem.rlast = 1'b0;
        gmem.rresp = '0; gmem.awready = 1'b0; gmem.wready = 1'b0; gmem.bvalid = 1'b0;
        gmem.bresp = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                gmem.arready = 1'b0; gmem.rvalid = 1'b0; gmem.rlast = 1'b0;
                gmem.awready = 1'b0; gmem.wready = 1'b0;
                rq.delete();
                r_hs_pend = 1'b0; ar_wait_prev = 1'b0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (io_done) begin done_cnt++; done_cyc = cyc; end
                if (gmem.rready && gmem.arvalid) rr_overlap++;
                if (ar_wait_prev && (!gmem.arvalid || gmem.araddr !== ar_addr_prev ||
                                     gmem.arlen !== ar_len_prev)) ar_drop++;
                // Read data: a presented beat is held until taken, otherwise random gaps.
                keep = gmem.rvalid && !r_hs_pend;
                if (r_hs_pend) void'(rq.pop_front());
                if (rq.size() > 0 && (keep || $urandom_range(0, 3) != 0)) begin
                    gmem.rvalid = 1'b1; gmem.rdata = rq[0].data; gmem.rlast = rq[0].last;
                end else begin
                    gmem.rvalid = 1'b0; gmem.rlast = 1'b0;
                end
                r_hs_pend = gmem.rvalid && gmem.rready;
                // Read address: beats become visible only after the handshake edge.
                ar_hs = 1'b0;
                if (gmem.arvalid) begin
                    gmem.arready = (ar_cnt >= ar_delay);
                    ar_cnt++;
                    if (gmem.arready) begin
                        ar_hs = 1'b1; ar_cnt = 0;
                        ar_log.push_back(a_rec_t'{gmem.araddr, gmem.arlen});
                        nb = int'(gmem.arlen) + 1;
                        if (gmem.arlen == '0 && extra_arg_beats > 0) nb = 1 + extra_arg_beats;
                        for (int k = 0; k < nb; k++)
                            rq.push_back(beat_t'{rd(gmem.araddr + ADDR_W'(32 * k)), k == nb - 1});
                    end
                end else begin
                    gmem.arready = 1'b0; ar_cnt = 0;
                end
                ar_wait_prev = gmem.arvalid && !ar_hs;
                ar_addr_prev = gmem.araddr;
                ar_len_prev  = gmem.arlen;
                // Write address and data
                if (gmem.awvalid) begin
                    aw_valid_cycles++;
                    gmem.awready = (aw_cnt >= aw_delay);
                    aw_cnt++;
                    if (gmem.awready) begin
                        aw_log.push_back(a_rec_t'{gmem.awaddr, gmem.awlen}); aw_cnt = 0;
                    end
                end else begin
                    gmem.awready = 1'b0; aw_cnt = 0;
                end
                if (gmem.wvalid) begin
                    w_valid_cycles++;
                    gmem.wready = (w_cnt >= w_delay);
                    w_cnt++;
                    if (gmem.wready) begin
                        w_log.push_back(w_rec_t'{gmem.wdata, gmem.wlast, gmem.wstrb});
                        w_cnt = 0; w_hs_cyc = cyc;
                    end
                end else begin
                    gmem.wready = 1'b0; w_cnt = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); w_log.delete();
        done_cnt = 0; aw_valid_cycles = 0; w_valid_cycles = 0;
    endtask

    // One complete run with all per-run checks.
    task automatic do_run(input logic [63:0] pa, input logic [63:0] pd, input logic [63:0] pr,
                          input string tag);
        logic [DATA_W-1:0] exp_r;
        logic [31:0] exp_s;
        bit seen;
        exp_r = model_res(rd(pa[ADDR_W-1:0]), rd(pd[ADDR_W-1:0]), rd(pd[ADDR_W-1:0] + ADDR_W'(32)));
        exp_s = model_sum(exp_r);
        @(negedge clock);
        io_pargs = pa; io_pdata = pd; io_pres = pr;
        clear_logs();
        io_start = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (io_done) seen = 1'b1;
        end
        check({tag, "/done_seen"}, seen, 1);
        check({tag, "/ap_return"}, io_ap_return, exp_s);
        @(negedge clock);
        check({tag, "/done_width"}, io_done, 0);
        check({tag, "/done_count"}, done_cnt, 1);
        check({tag, "/ar_count"}, ar_log.size(), 2);
        check({tag, "/ar0_addr"}, ar_log[0].addr, pa[ADDR_W-1:0]);
        check({tag, "/ar0_len"}, ar_log[0].len, 0);
        check({tag, "/ar1_addr"}, ar_log[1].addr, pd[ADDR_W-1:0]);
        check({tag, "/ar1_len"}, ar_log[1].len, 1);
        check({tag, "/aw_count"}, aw_log.size(), 1);
        check({tag, "/aw_addr"}, aw_log[0].addr, pr[ADDR_W-1:0]);
        check({tag, "/aw_len"}, aw_log[0].len, 0);
        check({tag, "/w_count"}, w_log.size(), 1);
        check({tag, "/wdata"}, w_log[0].data, exp_r);
        check({tag, "/wlast"}, w_log[0].last, 1);
        check({tag, "/wstrb"}, w_log[0].strb, {(DATA_W/8){1'b1}});
    endtask

    initial begin
        logic [DATA_W-1:0] arg, a, b, exp_r, lane_word;
        logic [31:0] exp_s;
        logic [63:0] pa, pd, pr;
        int seen, arg_reads;
        bit got;

        // Reset state
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset/arvalid", gmem.arvalid, 0);
        check("reset/awvalid", gmem.awvalid, 0);
        check("reset/wvalid", gmem.wvalid, 0);
        check("reset/rready", gmem.rready, 0);
        check("reset/io_done", io_done, 0);
        check("reset/ap_return", io_ap_return, 0);
        #2 reset = 1'b1;

        // Directed vector with pargs=0, pdata=0x40, pres=0x100
        mem[33'h0]  = 256'h00000011_00000012_00000013_00000014_00000005_00000006_00000007_00000008;
        mem[33'h40] = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
        mem[33'h60] = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
        do_run(64'h0, 64'h40, 64'h100, "directed");
        check("directed/wdata_const", w_log[0].data,
              256'h00000013_00000016_00000019_0000001C_0000000F_00000012_00000015_00000018);
        check("directed/ap_return_const", io_ap_return, 32'hAC);
        check("const/arburst", gmem.arburst, 2'b01);
        check("const/arsize", gmem.arsize, 3'b101);
        check("const/arcache", gmem.arcache, 4'b0011);
        check("const/awburst", gmem.awburst, 2'b01);
        check("const/bready", gmem.bready, 1);
        repeat (5) @(negedge clock);
        check("directed/ap_return_held", io_ap_return, 32'hAC);

        // Slow ARREADY, pointer with bits above the address width
        pa = 64'h0000_0100_0000_1000; pd = 64'h2040; pr = 64'h3000;
        mem[33'h1000] = rand_vec(); mem[33'h2040] = rand_vec(); mem[33'h2060] = rand_vec();
        ar_delay = 5;
        do_run(pa, pd, pr, "ar_delay");
        ar_delay = 0;

        // WREADY held low for 3 cycles while AWREADY is immediate
        w_delay = 3;
        do_run(pa, pd, 64'h8000_0000_0000_3100, "w_delay");
        check("w_delay/aw_valid_cycles", aw_valid_cycles, 1);
        check("w_delay/w_valid_cycles", w_valid_cycles, 4);
        check("w_delay/done_after_w", done_cyc > w_hs_cyc, 1);
        w_delay = 0;

        // Random operands, including an ARG burst with extra beats to drain
        for (int t = 0; t < 4; t++) begin
            pa = 64'h4000 + 64'(32 * $urandom_range(0, 15));
            pd = 64'h6000 + 64'(64 * $urandom_range(0, 15));
            pr = 64'h9000 + 64'(32 * $urandom_range(0, 15));
            for (int k = 0; k < 3; k++) mem[pa[ADDR_W-1:0] + ADDR_W'(32 * k)] = rand_vec();
            mem[pd[ADDR_W-1:0]] = rand_vec();
            mem[pd[ADDR_W-1:0] + ADDR_W'(32)] = rand_vec();
            extra_arg_beats = (t == 1) ? 3 : 0;
            aw_delay = $urandom_range(0, 2);
            w_delay  = $urandom_range(0, 2);
            do_run(pa, pd, pr, $sformatf("rand%0d", t));
        end
        extra_arg_beats = 0; aw_delay = 0; w_delay = 0;

        // Back-to-back runs with io_start held; lane 0 overflows to zero
        arg = rand_vec(); a = rand_vec(); b = rand_vec();
        arg[31:0] = 32'hFFFF_FFFF; a[31:0] = 32'h1; b[31:0] = 32'h0;
        pa = 64'hA000; pd = 64'hB000; pr = 64'hC000;
        mem[33'hA000] = arg; mem[33'hB000] = a; mem[33'hB020] = b;
        exp_r = model_res(arg, a, b);
        exp_s = model_sum(exp_r);
        @(negedge clock);
        io_pargs = pa; io_pdata = pd; io_pres = pr;
        clear_logs();
        io_start = 1'b1;
        seen = 0;
        for (int i = 0; i < 1500 && seen < 3; i++) begin
            @(negedge clock);
            if (io_done) begin
                seen++;
                check($sformatf("b2b/ap_return%0d", seen), io_ap_return, exp_s);
                if (seen == 3) io_start = 1'b0;
            end
        end
        check("b2b/runs", seen, 3);
        repeat (10) @(negedge clock);
        check("b2b/done_count", done_cnt, 3);
        check("b2b/ar_count", ar_log.size(), 6);
        arg_reads = 0;
        foreach (ar_log[i]) if (ar_log[i].addr == pa[ADDR_W-1:0] && ar_log[i].len == '0) arg_reads++;
        check("b2b/arg_reads", arg_reads, 3);
        check("b2b/w_count", w_log.size(), 3);
        foreach (w_log[i]) check($sformatf("b2b/wdata%0d", i), w_log[i].data, exp_r);
        lane_word = w_log[0].data;
        check("b2b/lane0_wrap", lane_word[31:0], 0);

        // Reset in the middle of a run
        ar_delay = 1000;
        @(negedge clock);
        io_start = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (gmem.arvalid) got = 1'b1;
        end
        check("abort/arvalid_seen", got, 1);
        #2 reset = 1'b0;
        #1;
        check("abort/arvalid", gmem.arvalid, 0);
        check("abort/rready", gmem.rready, 0);
        check("abort/io_done", io_done, 0);
        check("abort/ap_return", io_ap_return, 0);
        ar_delay = 0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        do_run(64'h0, 64'h40, 64'h100, "after_abort");

        check("bus/ar_held_until_hs", ar_drop, 0);
        check("bus/no_rready_during_ar", rr_overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end
endmodule
